// File: rtl/param_misr_ora.sv
// param_misr_ora: multiple-input signature register with golden-signature verdict FSM
module param_misr_ora #(
    parameter int                 WIDTH    = 4,
    parameter int                 IN_WIDTH = 2,
    parameter logic [WIDTH-1:0]   POLY     = 4'h3,
    parameter logic [WIDTH-1:0]   SEED     = 4'h0,
    parameter int                 PATTERNS = 7,
    parameter logic [WIDTH-1:0]   GOLDEN   = 4'h7
) (
    input  logic                              clock_i,
    input  logic                              reset_i,
    input  logic                              start_i,
    input  logic                              data_valid_i,
    input  logic [IN_WIDTH-1:0]               data_in_i,
    output logic [WIDTH-1:0]                  data_out_o,
    output logic [$clog2(PATTERNS+1)-1:0]     sample_count_o,
    output logic                              busy_o,
    output logic                              done_o,
    output logic                              pass_o,
    output logic                              fail_o
);
    localparam int CW = $clog2(PATTERNS + 1);
    localparam logic [CW-1:0] LAST = CW'(PATTERNS - 1);

    if (IN_WIDTH > WIDTH || IN_WIDTH < 1 || PATTERNS < 1 || WIDTH < 2) begin : g_bad_params
        $error("param_misr_ora: illegal WIDTH/IN_WIDTH/PATTERNS combination");
    end

    typedef enum logic [1:0] {IDLE, COMPACT, CHECK, DONE} state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  sig_q, sig_d;
    logic [CW-1:0]     cnt_q;
    logic              done_q, pass_q, fail_q;

    // Next signature: shift up, fold the MSB back through the tap mask, mix in the response
    always_comb sig_d = {sig_q[WIDTH-2:0], 1'b0} ^ (POLY & {WIDTH{sig_q[WIDTH-1]}}) ^ WIDTH'(data_in_i);

    // Session FSM: compact PATTERNS responses, then one cycle to compare against GOLDEN
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            sig_q   <= SEED;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: if (start_i) begin
                    state_q <= COMPACT;
                    sig_q   <= SEED;
                    cnt_q   <= '0;
                    done_q  <= 1'b0;
                    pass_q  <= 1'b0;
                    fail_q  <= 1'b0;
                end
                COMPACT: if (data_valid_i) begin
                    sig_q <= sig_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST) state_q <= CHECK;
                end
                CHECK: begin
                    pass_q  <= (sig_q == GOLDEN);
                    fail_q  <= (sig_q != GOLDEN);
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
            endcase
        end
    end

    assign data_out_o     = sig_q;
    assign sample_count_o = cnt_q;
    assign busy_o         = (state_q == COMPACT) || (state_q == CHECK);
    assign done_o         = done_q;
    assign pass_o         = pass_q;
    assign fail_o         = fail_q;
endmodule

// File: tb/tb_param_misr_ora.sv
// tb_param_misr_ora: directed, table-driven check of the MISR output response analyser
module tb_param_misr_ora;
    typedef struct {
        logic [1:0] din;
        logic [3:0] sig;
        logic [2:0] cnt;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, start, dv;
    logic [1:0] din;
    logic [3:0] sig;
    logic [2:0] cnt;
    logic       busy, done, pass, fail;
    int         checks = 0;
    int         errors = 0;
    vec_t       good_v [7];
    vec_t       bad_v  [7];

    always #5 clk = ~clk;

    param_misr_ora dut (
        .clock_i        (clk),
        .reset_i        (rst),
        .start_i        (start),
        .data_valid_i   (dv),
        .data_in_i      (din),
        .data_out_o     (sig),
        .sample_count_o (cnt),
        .busy_o         (busy),
        .done_o         (done),
        .pass_o         (pass),
        .fail_o         (fail)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic s, input logic v, input logic [1:0] d);
        start = s;
        dv    = v;
        din   = d;
        @(negedge clk);
    endtask

    task automatic run_vecs(input bit bad, input bit gaps, input int lo, input int hi);
        vec_t v;
        for (int i = lo; i <= hi; i++) begin
            v = bad ? bad_v[i] : good_v[i];
            step(1'b0, 1'b1, v.din);
            chk($sformatf("sig[%0d]", i), sig, v.sig);
            chk($sformatf("cnt[%0d]", i), cnt, v.cnt);
            chk($sformatf("busy[%0d]", i), busy, 1);
            if (gaps && i < 6) begin
                step(1'b0, 1'b0, 2'b11);
                chk($sformatf("gap_sig[%0d]", i), sig, v.sig);
                chk($sformatf("gap_cnt[%0d]", i), cnt, v.cnt);
            end
        end
    endtask

    task automatic begin_session();
        step(1'b1, 1'b0, 2'b00);
        chk("start_sig", sig, 0);
        chk("start_cnt", cnt, 0);
        chk("start_busy", busy, 1);
        chk("start_done", done, 0);
        chk("start_pass", pass, 0);
        chk("start_fail", fail, 0);
    endtask

    task automatic finish_session(input bit exp_pass, input logic [3:0] exp_sig);
        chk("check_done", done, 0);
        chk("check_busy", busy, 1);
        step(1'b0, 1'b1, 2'b11);
        chk("verdict_done", done, 1);
        chk("verdict_pass", pass, exp_pass);
        chk("verdict_fail", fail, !exp_pass);
        chk("verdict_excl", pass & fail, 0);
        chk("verdict_busy", busy, 0);
        step(1'b0, 1'b1, 2'b01);
        chk("hold_sig", sig, exp_sig);
        chk("hold_cnt", cnt, 7);
        chk("hold_done", done, 1);
        chk("hold_pass", pass, exp_pass);
    endtask

    initial begin
        good_v = '{'{2'b10, 4'h2, 3'd1}, '{2'b01, 4'h5, 3'd2}, '{2'b01, 4'hB, 3'd3},
                   '{2'b11, 4'h6, 3'd4}, '{2'b01, 4'hD, 3'd5}, '{2'b10, 4'hB, 3'd6},
                   '{2'b10, 4'h7, 3'd7}};
        bad_v  = '{'{2'b10, 4'h2, 3'd1}, '{2'b01, 4'h5, 3'd2}, '{2'b01, 4'hB, 3'd3},
                   '{2'b10, 4'h7, 3'd4}, '{2'b01, 4'hF, 3'd5}, '{2'b10, 4'hF, 3'd6},
                   '{2'b10, 4'hF, 3'd7}};
        rst = 1'b1; start = 1'b0; dv = 1'b0; din = 2'b00;
        @(negedge clk);
        @(negedge clk);
        chk("rst_sig", sig, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_fail", fail, 0);
        rst = 1'b0;
        step(1'b0, 1'b1, 2'b11);
        chk("idle_ignore_sig", sig, 0);
        chk("idle_ignore_cnt", cnt, 0);
        // basic passing session
        begin_session();
        run_vecs(1'b0, 1'b0, 0, 6);
        finish_session(1'b1, 4'h7);
        // restart from DONE, with dataValid gaps
        begin_session();
        run_vecs(1'b0, 1'b1, 0, 6);
        finish_session(1'b1, 4'h7);
        // corrupted fourth response
        begin_session();
        run_vecs(1'b1, 1'b0, 0, 6);
        finish_session(1'b0, 4'hF);
        // start pulsed mid-session is ignored
        begin_session();
        run_vecs(1'b0, 1'b0, 0, 2);
        step(1'b1, 1'b0, 2'b00);
        chk("mid_start_sig", sig, 4'hB);
        chk("mid_start_cnt", cnt, 3);
        chk("mid_start_busy", busy, 1);
        step(1'b1, 1'b1, good_v[3].din);
        chk("mid_start_acc_sig", sig, 4'h6);
        chk("mid_start_acc_cnt", cnt, 4);
        run_vecs(1'b0, 1'b0, 4, 6);
        finish_session(1'b1, 4'h7);
        // asynchronous reset mid-session
        begin_session();
        run_vecs(1'b0, 1'b0, 0, 3);
        #2 rst = 1'b1;
        #1;
        chk("arst_sig", sig, 0);
        chk("arst_cnt", cnt, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        #1 rst = 1'b0;
        @(negedge clk);
        step(1'b0, 1'b1, 2'b10);
        chk("post_rst_idle_sig", sig, 0);
        chk("post_rst_idle_busy", busy, 0);
        chk("post_rst_idle_done", done, 0);
        begin_session();
        run_vecs(1'b0, 1'b0, 0, 6);
        finish_session(1'b1, 4'h7);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/param_misr_ora.md
PARAM_MISR_ORA -- requirements
Module: param_misr_ora

Interface
REQ-001 Parameter WIDTH, default 4: signature register width (>=2).
REQ-002 Parameter IN_WIDTH, default 2: compacted response width, 1 <= IN_WIDTH <= WIDTH.
REQ-003 Parameter POLY, default 4'h3: feedback tap mask; POLY[i]=1 XORs the feedback bit into stage i (x^4+x+1).
REQ-004 Parameter SEED, default 4'h0: signature value loaded at reset and at each session start.
REQ-005 Parameter PATTERNS, default 7: responses compacted per session (>=1).
REQ-006 Parameter GOLDEN, default 4'h7: expected fault-free signature.
REQ-007 clock  input  1  single clock; all state updates on its rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 start  input  1  begin a session; sampled on the rising edge.
REQ-010 dataValid  input  1  dataIn carries a valid response this cycle.
REQ-011 dataIn  input  IN_WIDTH  circuit-under-test response; bit0=Sum, bit1=Cout for the full-adder BIST.
REQ-012 dataOut  output  WIDTH  current signature register.
REQ-013 sampleCount  output  clog2(PATTERNS+1)  responses accepted in the current session.
REQ-014 busy  output  1  high in COMPACT and CHECK.
REQ-015 done  output  1  session complete; verdict valid.
REQ-016 pass  output  1  final signature equals GOLDEN.
REQ-017 fail  output  1  final signature differs from GOLDEN.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, COMPACT, CHECK, DONE.
REQ-019 IDLE or DONE with start=1 -> COMPACT; dataOut<=SEED, sampleCount<=0, done/pass/fail<=0.
REQ-020 start SHALL be ignored in COMPACT and CHECK; no restart mid-session.
REQ-021 A response is accepted on an edge only when state=COMPACT and dataValid=1; dataOut and sampleCount hold otherwise.
REQ-022 On acceptance, with fb=dataOut[WIDTH-1] and d[i]=dataIn[i] for i<IN_WIDTH (0 otherwise): next[0]=(POLY[0]&fb)^d[0]; next[i]=dataOut[i-1]^(POLY[i]&fb)^d[i] for i>=1.
REQ-023 The edge accepting response number PATTERNS SHALL increment sampleCount to PATTERNS and move COMPACT -> CHECK.
REQ-024 CHECK SHALL last one cycle: pass<=(dataOut==GOLDEN), fail<=~(dataOut==GOLDEN), done<=1, then DONE.
REQ-025 done rises exactly one clock after the final accepted response; pass and fail SHALL never both be 1.
REQ-026 DONE SHALL hold dataOut, sampleCount, done, pass and fail until start or reset; dataValid is ignored.
REQ-027 In IDLE, CHECK and DONE, dataIn and dataValid SHALL have no effect.
REQ-028 Elaboration SHALL fail if IN_WIDTH>WIDTH, PATTERNS<1, or WIDTH<2.

Reset
REQ-029 reset=1 SHALL immediately, independent of clock, force state=IDLE, dataOut=SEED, sampleCount=0, busy=done=pass=fail=0.
REQ-030 reset asserted mid-session SHALL abort it with no verdict; the next session requires a new start.

Verification
REQ-031 Defaults; reset; start; dataValid=1 with dataIn 10,01,01,11,01,10,10 -> dataOut 2,5,B,6,D,B,7 (hex), sampleCount=7, next cycle done=1 pass=1 fail=0.
REQ-032 Same as REQ-031 but 4th response 10 instead of 11 -> final dataOut != 7, done=1 pass=0 fail=1.
REQ-033 Same as REQ-031 with dataValid=0 gaps between responses -> identical signatures, dataOut and sampleCount held through gaps, same pass.
REQ-034 start pulsed while busy after 3 responses -> ignored; session completes as REQ-031.
REQ-035 reset pulsed asynchronously (between edges) after 4 responses -> dataOut=0, IDLE, done=0; new start plus full sequence -> pass=1.
REQ-036 Start in DONE -> dataOut=SEED, done/pass/fail cleared on that edge; second identical session -> pass=1.
